alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised, handshaked execute unit for the MiniAlu-class core: takes one operation plus two operands per transaction, produces a registered result and status flags. Single-cycle ops (add/sub/logic/shift) run at full throughput. Signed and unsigned multiply run as a multi-cycle shift-add sequence, replacing the combinational 16×16 multiplier. Sits between operand fetch (register-file forwarding) and write-back; the decoder stalls on `oReady`.

## Interface
- `DATA_W`, 16: operand width (≥4, power of two).
- `SHAMT_W`, $clog2(DATA_W): shift-amount bits taken from `iB`.
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `iValid` in 1: request valid.
- `oReady` out 1: unit can accept a request this cycle.
- `iOp` in 4: opcode (package constants).
- `iA`, `iB` in DATA_W: operands.
- `oValid` out 1: result valid, held until taken.
- `iReady` in 1: consumer takes the result.
- `oResult` out 2*DATA_W: result; upper half zero for non-multiply ops.
- `oFlags` out 5: {ERR, V, C, N, Z}.
- `oBusy` out 1: multiply in progress.

## Operation
- Ops: ADD, SUB (A−B), AND, OR, XOR, SHL, SHR (logical), ASR, UMUL, SMUL. Any other code: result 0, ERR=1, other flags 0, single-cycle.
- Accept when `iValid && oReady`. Operands and op are captured; later input changes are ignored.
- FSM states:
  - IDLE: `oReady`=1. Accept of a single-cycle op goes to DONE. Accept of a MUL goes to MUL.
  - MUL: `oReady`=0, `oBusy`=1. Runs DATA_W iterations, then one finalize cycle, then goes to DONE.
  - DONE: `oValid`=1. `oReady`=`iReady`.
    - `iReady` with a new single-cycle accept: stay in DONE with the new result.
    - `iReady` with a MUL accept: go to MUL.
    - `iReady` with no accept: go to IDLE.
    - No `iReady`: hold `oResult` and `oFlags` stable.
- ADD/SUB:
  - Computed at DATA_W+1 bits. C = carry out (ADD) or no-borrow (SUB, C=1 when A≥B unsigned).
  - V = signed overflow.
  - N = result[DATA_W-1]. Z = (result[DATA_W-1:0]==0).
- Logic ops: C=V=0.
- Shifts: amount = `iB[SHAMT_W-1:0]`, higher bits of `iB` ignored. C = last bit shifted out (0 when amount is 0). V=0.
- UMUL: unsigned 2*DATA_W product.
- SMUL:
  - Magnitudes of A and B are multiplied unsigned. The finalize cycle negates the product if the operand signs differ.
  - Most-negative × most-negative = +2^(2·DATA_W−2), which is representable.
- MUL flags: Z and N are taken from the full 2*DATA_W product. C=V=ERR=0.
- Reset, at any time including mid-multiply:
  - FSM to IDLE.
  - `oValid`=0, `oBusy`=0, `oResult`=0, `oFlags`=0.
  - `oReady`=1 from the first edge after deassertion.

## Timing
- Single-cycle op accepted at edge n: `oValid`=1 after edge n+1 (latency 1).
- Back-to-back single-cycle throughput is 1 per cycle while `iReady`=1.
- MUL accepted at edge n: `oValid`=1 after edge n+DATA_W+1. For DATA_W=16 that is latency 17.
- The iteration counter is $clog2(DATA_W)+1 bits wide. It counts DATA_W−1 down to 0 with no wrap.
- `oReady` is combinational from state and `iReady`. There is no combinational path from `iValid` to any output.
- When `oValid` and `iReady` are high and a new request is accepted on the same edge, the new result replaces the old one with no bubble.

## Structure
- Package `alu_exec_pkg`:
  - opcode localparams (ADD=0 … SMUL=9)
  - flag bit indices
  - FSM state encoding (IDLE, MUL, DONE)
- Sub-module `seq_multiplier`:
  - shift-add core: start pulse, signed/unsigned select, done pulse, 2*DATA_W product.
  - Reset behaviour: async reset, same as the top.
- The top holds the FSM, the single-cycle datapath, and the output registers.

## Test plan
- ADD `iA`=0x7FFF, `iB`=0x0001 → after 1 cycle: `oResult`=0x00008000, flags V=1 N=1 C=0 Z=0.
- SUB `iA`=0x0003, `iB`=0x0005 → `oResult`=0x0000FFFE, N=1, C=0; then SUB 5−5 → 0, Z=1, C=1.
- SMUL `iA`=0xFFFD, `iB`=0x0007 → `oValid` exactly 17 cycles after accept, `oResult`=0xFFFFFFEB, N=1. Then SMUL 0x8000×0x8000 → 0x40000000.
- Backpressure: ADD 1+2 with `iReady` low for 3 cycles → `oResult`=3 held stable, `oReady`=0. `iReady` high together with a new request XOR 0xF0F0^0x0FF0 → 0x0000FF00 on the next cycle, no bubble.
- Shift and illegal op: SHL 0x0001 by `iB`=0x0013 → 0x00000008 (amount 3). Opcode 0xF → result 0, ERR=1.
- Reset asserted 5 cycles into UMUL 0xFFFF×0xFFFF → all outputs 0 immediately. After release, UMUL 0xFFFF×0xFFFF → 0xFFFE0001 at latency 17.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute unit: opcodes, flag bit positions, FSM encoding.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package alu_exec_pkg;

    // Opcodes carried on iOp
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_ASR  = 4'd7;
    localparam logic [3:0] OP_UMUL = 4'd8;
    localparam logic [3:0] OP_SMUL = 4'd9;

    // Bit positions inside oFlags = {ERR, V, C, N, Z}
    localparam int FLAG_W   = 5;
    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ERR = 4;

    // Top-level FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_UMUL) || (op == OP_SMUL);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: signed or unsigned DATA_W x DATA_W -> 2*DATA_W product.
// Latency: start pulse at edge n, o_done high for the cycle after edge n+DATA_W.
// Backpressure: none; o_done is a one-cycle pulse and the caller must sample it.
//
// Ports:
//   Clock, Reset      clock and async active-high reset
//   i_start           load operands and begin (ignored-safe while running: restarts)
//   i_signed          treat operands as two's complement
//   i_a, i_b          operands, sampled only on i_start
//   o_done            finalize cycle; o_product is valid while this is high
//   o_product         2*DATA_W product
module seq_multiplier
#(
    parameter int DATA_W = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  i_start,
    input  logic                  i_signed,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_run;
    logic                r_fin;
    logic                r_neg;

    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;

    // Magnitude of the most-negative value wraps to itself, which read as
    // unsigned is exactly the wanted magnitude 2^(DATA_W-1).
    assign w_a_mag = (i_signed && i_a[DATA_W-1]) ? -i_a : i_a;
    assign w_b_mag = (i_signed && i_b[DATA_W-1]) ? -i_b : i_b;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_fin    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= i_signed & (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
            r_cnt    <= CNT_INIT;
            r_run    <= 1'b1;
            r_fin    <= 1'b0;
        end else if (r_run) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            // Iteration with count 0 is the last one; the counter never wraps.
            if (r_cnt == '0) begin
                r_run <= 1'b0;
                r_fin <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else begin
            r_fin <= 1'b0;
        end
    end

    // Sign fix-up happens in the finalize cycle, straight into the caller's register.
    assign o_done    = r_fin;
    assign o_product = r_neg ? -r_acc : r_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute unit: single-cycle ALU ops plus multi-cycle shift-add multiply.
// Latency: 1 cycle for ALU ops, DATA_W+1 cycles for UMUL/SMUL.
// Backpressure: oReady drops while multiplying or while a result waits for iReady.
//
// Ports:
//   Clock, Reset           clock and async active-high reset
//   iValid/oReady          request handshake; iOp, iA, iB captured on accept
//   oValid/iReady          result handshake; oResult, oFlags held until taken
//   oResult                2*DATA_W result, upper half zero for non-multiply ops
//   oFlags                 {ERR, V, C, N, Z}
//   oBusy                  multiply in progress
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [3:0]            iOp,
    input  logic [DATA_W-1:0]     iA,
    input  logic [DATA_W-1:0]     iB,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [2*DATA_W-1:0]   oResult,
    output logic [FLAG_W-1:0]     oFlags,
    output logic                  oBusy
);

    logic [1:0]            r_state;
    logic [2*DATA_W-1:0]   r_result;
    logic [FLAG_W-1:0]     r_flags;
    logic                  r_live;

    logic                  w_accept;
    logic                  w_is_mul;
    logic                  w_mul_start;
    logic                  w_mul_done;
    logic [2*DATA_W-1:0]   w_product;
    logic [FLAG_W-1:0]     w_mul_flags;

    logic [SHAMT_W-1:0]    w_amt;
    logic [DATA_W:0]       w_sum;
    logic [DATA_W:0]       w_diff;
    logic [DATA_W:0]       w_shl;
    logic [DATA_W:0]       w_shr;
    logic [DATA_W:0]       w_asr;
    logic [DATA_W-1:0]     w_sc_result;
    logic [FLAG_W-1:0]     w_sc_flags;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // r_live keeps oReady low while Reset is held and raises it on the
    // first edge after release.
    assign oReady      = r_live & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & iReady));
    assign oValid      = (r_state == ST_DONE);
    assign oBusy       = (r_state == ST_MUL);
    assign oResult     = r_result;
    assign oFlags      = r_flags;

    assign w_accept    = iValid & oReady;
    assign w_is_mul    = is_mul_op(iOp);
    assign w_mul_start = w_accept & w_is_mul;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_amt  = iB[SHAMT_W-1:0];
    assign w_sum  = {1'b0, iA} + {1'b0, iB};
    assign w_diff = {1'b0, iA} - {1'b0, iB};
    // One guard bit on the shifted-out side catches the last bit lost;
    // it stays 0 for a zero shift amount.
    assign w_shl  = {1'b0, iA} << w_amt;
    assign w_shr  = {iA, 1'b0} >> w_amt;
    assign w_asr  = $signed({iA, 1'b0}) >>> w_amt;

    always_comb begin
        w_sc_result = '0;
        w_sc_flags  = '0;
        case (iOp)
            OP_ADD: begin
                w_sc_result        = w_sum[DATA_W-1:0];
                w_sc_flags[FLAG_C] = w_sum[DATA_W];
                w_sc_flags[FLAG_V] = (iA[DATA_W-1] == iB[DATA_W-1]) &&
                                     (w_sum[DATA_W-1] != iA[DATA_W-1]);
            end
            OP_SUB: begin
                w_sc_result        = w_diff[DATA_W-1:0];
                // Carry means "no borrow", i.e. A >= B unsigned.
                w_sc_flags[FLAG_C] = ~w_diff[DATA_W];
                w_sc_flags[FLAG_V] = (iA[DATA_W-1] != iB[DATA_W-1]) &&
                                     (w_diff[DATA_W-1] != iA[DATA_W-1]);
            end
            OP_AND: w_sc_result = iA & iB;
            OP_OR:  w_sc_result = iA | iB;
            OP_XOR: w_sc_result = iA ^ iB;
            OP_SHL: begin
                w_sc_result        = w_shl[DATA_W-1:0];
                w_sc_flags[FLAG_C] = w_shl[DATA_W];
            end
            OP_SHR: begin
                w_sc_result        = w_shr[DATA_W:1];
                w_sc_flags[FLAG_C] = w_shr[0];
            end
            OP_ASR: begin
                w_sc_result        = w_asr[DATA_W:1];
                w_sc_flags[FLAG_C] = w_asr[0];
            end
            OP_UMUL, OP_SMUL: begin
                // Handled by the multiplier; this path is never loaded.
                w_sc_result = '0;
            end
            default: begin
                w_sc_flags[FLAG_ERR] = 1'b1;
            end
        endcase
        if (!w_sc_flags[FLAG_ERR]) begin
            w_sc_flags[FLAG_N] = w_sc_result[DATA_W-1];
            w_sc_flags[FLAG_Z] = (w_sc_result == '0);
        end
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    seq_multiplier #(
        .DATA_W    (DATA_W)
    ) u_mul (
        .Clock     (Clock),
        .Reset     (Reset),
        .i_start   (w_mul_start),
        .i_signed  (iOp == OP_SMUL),
        .i_a       (iA),
        .i_b       (iB),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_mul_flags         = '0;
        w_mul_flags[FLAG_N] = w_product[2*DATA_W-1];
        w_mul_flags[FLAG_Z] = (w_product == '0);
    end

    // ------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_flags  <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if ((r_state == ST_MUL) && w_mul_done) begin
                r_state  <= ST_DONE;
                r_result <= w_product;
                r_flags  <= w_mul_flags;
            end else if (w_accept) begin
                // Accept from IDLE, or from DONE with iReady: the new result
                // overwrites the taken one on the same edge, no bubble.
                if (w_is_mul) begin
                    r_state <= ST_MUL;
                end else begin
                    r_state  <= ST_DONE;
                    r_result <= {{DATA_W{1'b0}}, w_sc_result};
                    r_flags  <= w_sc_flags;
                end
            end else if ((r_state == ST_DONE) && iReady) begin
                r_state <= ST_IDLE;
            end else if ((r_state != ST_IDLE) && (r_state != ST_MUL) &&
                         (r_state != ST_DONE)) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        Clock;
    logic        Reset;
    logic        iValid;
    logic        oReady;
    logic [3:0]  iOp;
    logic [15:0] iA;
    logic [15:0] iB;
    logic        oValid;
    logic        iReady;
    logic [31:0] oResult;
    logic [4:0]  oFlags;
    logic        oBusy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(
        .DATA_W  (16),
        .SHAMT_W (4)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .iValid  (iValid),
        .oReady  (oReady),
        .iOp     (iOp),
        .iA      (iA),
        .iB      (iB),
        .oValid  (oValid),
        .iReady  (iReady),
        .oResult (oResult),
        .oFlags  (oFlags),
        .oBusy   (oBusy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        iValid = 1'b1;
        iOp    = op;
        iA     = a;
        iB     = b;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", oValid); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", oBusy); end
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", oReady); end
        checks++; if (oResult !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", oResult); end
        checks++; if (oFlags !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 0", oFlags); end
        Reset = 1'b0;
        @(posedge Clock); #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", oReady); end
    endtask

    task automatic test_add;
        drive(4'd0, 16'h7FFF, 16'h0001);
        @(posedge Clock); #1;
        iValid = 1'b0;
        checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", oValid); end
        checks++; if (oResult !== 32'h0000_8000) begin errors++; $display("FAIL add_result got %h want 00008000", oResult); end
        checks++; if (oFlags !== 5'b01010) begin errors++; $display("FAIL add_flags got %b want 01010", oFlags); end
        @(posedge Clock); #1;
    endtask

    task automatic test_sub_back_to_back;
        drive(4'd1, 16'h0003, 16'h0005);
        @(posedge Clock); #1;
        checks++; if (oResult !== 32'h0000_FFFE) begin errors++; $display("FAIL sub_neg_result got %h want 0000fffe", oResult); end
        checks++; if (oFlags !== 5'b00010) begin errors++; $display("FAIL sub_neg_flags got %b want 00010", oFlags); end
        // Second request accepted on the edge that retires the first.
        drive(4'd1, 16'h0005, 16'h0005);
        @(posedge Clock); #1;
        iValid = 1'b0;
        checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL sub_b2b_valid got %b want 1", oValid); end
        checks++; if (oResult !== 32'h0) begin errors++; $display("FAIL sub_zero_result got %h want 0", oResult); end
        checks++; if (oFlags !== 5'b00101) begin errors++; $display("FAIL sub_zero_flags got %b want 00101", oFlags); end
        @(posedge Clock); #1;
    endtask

    task automatic test_smul;
        int cyc;
        drive(4'd9, 16'hFFFD, 16'h0007);
        @(posedge Clock); #1;
        iValid = 1'b0;
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL smul_busy got %b want 1", oBusy); end
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL smul_ready got %b want 0", oReady); end
        cyc = 0;
        while (!oValid && cyc < 40) begin @(posedge Clock); #1; cyc++; end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL smul_latency got %0d want 17", cyc); end
        checks++; if (oResult !== 32'hFFFF_FFEB) begin errors++; $display("FAIL smul_result got %h want ffffffeb", oResult); end
        checks++; if (oFlags !== 5'b00010) begin errors++; $display("FAIL smul_flags got %b want 00010", oFlags); end
        drive(4'd9, 16'h8000, 16'h8000);
        @(posedge Clock); #1;
        iValid = 1'b0;
        cyc = 0;
        while (!oValid && cyc < 40) begin @(posedge Clock); #1; cyc++; end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL smul_min_latency got %0d want 17", cyc); end
        checks++; if (oResult !== 32'h4000_0000) begin errors++; $display("FAIL smul_min_result got %h want 40000000", oResult); end
        checks++; if (oFlags !== 5'b00000) begin errors++; $display("FAIL smul_min_flags got %b want 00000", oFlags); end
        @(posedge Clock); #1;
    endtask

    task automatic test_backpressure;
        iReady = 1'b0;
        drive(4'd0, 16'h0001, 16'h0002);
        @(posedge Clock); #1;
        iValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (oValid !== 1'b1 || oResult !== 32'h3 || oFlags !== 5'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b r=%h f=%b want v=1 r=3 f=0", i, oValid, oResult, oFlags);
            end
            checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b want 0", i, oReady); end
            @(posedge Clock); #1;
        end
        iReady = 1'b1;
        drive(4'd4, 16'hF0F0, 16'h0FF0);
        #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", oReady); end
        @(posedge Clock); #1;
        iValid = 1'b0;
        checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL bp_xor_valid got %b want 1", oValid); end
        checks++; if (oResult !== 32'h0000_FF00) begin errors++; $display("FAIL bp_xor_result got %h want 0000ff00", oResult); end
        checks++; if (oFlags !== 5'b00010) begin errors++; $display("FAIL bp_xor_flags got %b want 00010", oFlags); end
        @(posedge Clock); #1;
    endtask

    task automatic test_shift_illegal;
        drive(4'd5, 16'h0001, 16'h0013);
        @(posedge Clock); #1;
        checks++; if (oResult !== 32'h0000_0008) begin errors++; $display("FAIL shl_result got %h want 00000008", oResult); end
        checks++; if (oFlags !== 5'b00000) begin errors++; $display("FAIL shl_flags got %b want 00000", oFlags); end
        drive(4'd6, 16'h0005, 16'h0001);
        @(posedge Clock); #1;
        checks++; if (oResult !== 32'h0000_0002) begin errors++; $display("FAIL shr_result got %h want 00000002", oResult); end
        checks++; if (oFlags !== 5'b00100) begin errors++; $display("FAIL shr_flags got %b want 00100", oFlags); end
        drive(4'd7, 16'h8001, 16'h0001);
        @(posedge Clock); #1;
        checks++; if (oResult !== 32'h0000_C000) begin errors++; $display("FAIL asr_result got %h want 0000c000", oResult); end
        checks++; if (oFlags !== 5'b00110) begin errors++; $display("FAIL asr_flags got %b want 00110", oFlags); end
        drive(4'hF, 16'h1234, 16'h5678);
        @(posedge Clock); #1;
        iValid = 1'b0;
        checks++; if (oResult !== 32'h0) begin errors++; $display("FAIL illegal_result got %h want 0", oResult); end
        checks++; if (oFlags !== 5'b10000) begin errors++; $display("FAIL illegal_flags got %b want 10000", oFlags); end
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_mid_mul;
        int cyc;
        drive(4'd8, 16'hFFFF, 16'hFFFF);
        @(posedge Clock); #1;
        iValid = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        checks++; if (oValid !== 1'b0 || oBusy !== 1'b0 || oReady !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl got v=%b b=%b r=%b want 0 0 0", oValid, oBusy, oReady);
        end
        checks++; if (oResult !== 32'h0 || oFlags !== 5'b0) begin
            errors++; $display("FAIL midreset_data got r=%h f=%b want 0 0", oResult, oFlags);
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
        checks++; if (oReady !== 1'b1 || oBusy !== 1'b0) begin
            errors++; $display("FAIL midreset_release got r=%b b=%b want 1 0", oReady, oBusy);
        end
        drive(4'd8, 16'hFFFF, 16'hFFFF);
        @(posedge Clock); #1;
        iValid = 1'b0;
        cyc = 0;
        while (!oValid && cyc < 40) begin @(posedge Clock); #1; cyc++; end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL umul_latency got %0d want 17", cyc); end
        checks++; if (oResult !== 32'hFFFE_0001) begin errors++; $display("FAIL umul_result got %h want fffe0001", oResult); end
        checks++; if (oFlags !== 5'b00010) begin errors++; $display("FAIL umul_flags got %b want 00010", oFlags); end
        @(posedge Clock); #1;
    endtask

    initial begin
        Reset  = 1'b1;
        iValid = 1'b0;
        iReady = 1'b1;
        iOp    = 4'd0;
        iA     = 16'h0;
        iB     = 16'h0;
        test_reset();
        test_add();
        test_sub_back_to_back();
        test_smul();
        test_backpressure();
        test_shift_illegal();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
